// File: rtl/spi_mem_ctrl_if.sv
// Memory request port shared by the CPU and debug/loader requesters.
//   req   : request level, held until done is seen
//   op    : 00 ROM read, 01 RAM read, 10 RAM write, 11 invalid
//   addr  : byte address
//   wdata : write data
//   done  : completion, high until req falls
// master modport belongs to the requester, slave modport to the controller.
interface spi_mem_ctrl_if;
   logic        req;
   logic [1:0]  op;
   logic [15:0] addr;
   logic [7:0]  wdata;
   logic        done;

   modport master (output req, op, addr, wdata, input done);
   modport slave  (input req, op, addr, wdata, output done);
endinterface

// File: rtl/spi_mem_ctrl.sv
// SPI master for the external memory: flash for ROM reads, PSRAM for RAM
// reads and writes. Arbitrates one SPI bus between the dbg port (priority)
// and the cpu port, runs a 40-bit frame {cmd, 00, addr, data} per request
// and answers with a four-phase done.
//   clk, rst      : system clock, asynchronous active-high reset
//   cpu, dbg      : request ports (slave side)
//   rdata         : last read byte, shared by both ports
//   busy          : controller not idle
//   spi_sclk      : SPI clock, mode 0
//   spi_mosi      : serial data out, MSB first
//   spi_miso      : serial data in
//   spi_cs_rom_n  : flash chip select, active low
//   spi_cs_ram_n  : PSRAM chip select, active low
module spi_mem_ctrl #(
   parameter int CLK_DIV = 1
) (
   input  logic           clk,
   input  logic           rst,
   spi_mem_ctrl_if.slave  cpu,
   spi_mem_ctrl_if.slave  dbg,
   output logic [7:0]     rdata,
   output logic           busy,
   output logic           spi_sclk,
   output logic           spi_mosi,
   input  logic           spi_miso,
   output logic           spi_cs_rom_n,
   output logic           spi_cs_ram_n
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {IDLE, START, SHIFT, FINISH, DONE} state_t;

   state_t             state_reg, state_next;
   logic               grant_reg, grant_next;      // 1 = dbg owns the bus
   logic [1:0]         op_reg, op_next;
   logic [15:0]        addr_reg, addr_next;
   logic [7:0]         wdata_reg, wdata_next;
   logic [39:0]        frame_reg, frame_next;
   logic [7:0]         rx_reg, rx_next;
   logic [DIV_W-1:0]   div_reg, div_next;
   logic [6:0]         edge_reg, edge_next;        // SCLK toggles so far
   logic               sclk_reg, sclk_next;
   logic               mosi_reg, mosi_next;
   logic               cs_rom_reg, cs_rom_next;
   logic               cs_ram_reg, cs_ram_next;
   logic [7:0]         rdata_reg, rdata_next;
   logic               cpu_done_reg, cpu_done_next;
   logic               dbg_done_reg, dbg_done_next;

   logic               div_last;
   logic               last_toggle;
   logic               gnt_req;
   logic               gnt_done;
   logic [39:0]        frame_load;

   assign div_last    = (div_reg == DIV_W'(CLK_DIV - 1));
   // 80 half-periods make the 40 SCLK periods; the 80th toggle is the final fall
   assign last_toggle = div_last && (edge_reg == 7'd79);
   assign gnt_req     = grant_reg ? dbg.req : cpu.req;
   assign gnt_done    = grant_reg ? dbg_done_reg : cpu_done_reg;
   assign frame_load  = {(op_reg == 2'b10) ? 8'h02 : 8'h03, 8'h00, addr_reg,
                         (op_reg == 2'b10) ? wdata_reg : 8'h00};

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   // next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (dbg.req)      state_next = (dbg.op == 2'b11) ? DONE : START;
            else if (cpu.req) state_next = (cpu.op == 2'b11) ? DONE : START;
         end
         START:  state_next = SHIFT;
         SHIFT:  if (last_toggle) state_next = FINISH;
         FINISH: state_next = DONE;
         DONE:   if (!gnt_req) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // output / datapath logic
   always_comb begin
      grant_next    = grant_reg;
      op_next       = op_reg;
      addr_next     = addr_reg;
      wdata_next    = wdata_reg;
      frame_next    = frame_reg;
      rx_next       = rx_reg;
      div_next      = div_reg;
      edge_next     = edge_reg;
      sclk_next     = sclk_reg;
      mosi_next     = mosi_reg;
      cs_rom_next   = cs_rom_reg;
      cs_ram_next   = cs_ram_reg;
      rdata_next    = rdata_reg;
      cpu_done_next = cpu_done_reg;
      dbg_done_next = dbg_done_reg;
      case (state_reg)
         IDLE: begin
            cpu_done_next = 1'b0;
            dbg_done_next = 1'b0;
            if (dbg.req) begin
               grant_next = 1'b1;
               op_next    = dbg.op;
               addr_next  = dbg.addr;
               wdata_next = dbg.wdata;
            end else if (cpu.req) begin
               grant_next = 1'b0;
               op_next    = cpu.op;
               addr_next  = cpu.addr;
               wdata_next = cpu.wdata;
            end
         end
         START: begin
            frame_next  = frame_load;
            mosi_next   = frame_load[39];
            cs_rom_next = (op_reg != 2'b00);
            cs_ram_next = (op_reg == 2'b00);
            sclk_next   = 1'b0;
            div_next    = '0;
            edge_next   = '0;
         end
         SHIFT: begin
            if (div_last) begin
               div_next  = '0;
               sclk_next = ~sclk_reg;
               edge_next = edge_reg + 7'd1;
               if (!sclk_reg) begin
                  rx_next = {rx_reg[6:0], spi_miso};
               end else begin
                  frame_next = {frame_reg[38:0], 1'b0};
                  mosi_next  = frame_reg[38];
               end
            end else begin
               div_next = div_reg + DIV_W'(1);
            end
         end
         FINISH: begin
            cs_rom_next = 1'b1;
            cs_ram_next = 1'b1;
            sclk_next   = 1'b0;
            mosi_next   = 1'b0;
            if (op_reg != 2'b10) rdata_next = rx_reg;
         end
         DONE: begin
            // First DONE cycle always raises done (even if req already fell);
            // afterwards done follows the granted req.
            if (grant_reg) dbg_done_next = gnt_req || !gnt_done;
            else           cpu_done_next = gnt_req || !gnt_done;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_reg    <= 1'b0;
         op_reg       <= 2'b00;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         frame_reg    <= '0;
         rx_reg       <= '0;
         div_reg      <= '0;
         edge_reg     <= '0;
         sclk_reg     <= 1'b0;
         mosi_reg     <= 1'b0;
         cs_rom_reg   <= 1'b1;
         cs_ram_reg   <= 1'b1;
         rdata_reg    <= '0;
         cpu_done_reg <= 1'b0;
         dbg_done_reg <= 1'b0;
      end else begin
         grant_reg    <= grant_next;
         op_reg       <= op_next;
         addr_reg     <= addr_next;
         wdata_reg    <= wdata_next;
         frame_reg    <= frame_next;
         rx_reg       <= rx_next;
         div_reg      <= div_next;
         edge_reg     <= edge_next;
         sclk_reg     <= sclk_next;
         mosi_reg     <= mosi_next;
         cs_rom_reg   <= cs_rom_next;
         cs_ram_reg   <= cs_ram_next;
         rdata_reg    <= rdata_next;
         cpu_done_reg <= cpu_done_next;
         dbg_done_reg <= dbg_done_next;
      end
   end

   assign cpu.done     = cpu_done_reg;
   assign dbg.done     = dbg_done_reg;
   assign rdata        = rdata_reg;
   assign busy         = (state_reg != IDLE);
   assign spi_sclk     = sclk_reg;
   assign spi_mosi     = mosi_reg;
   assign spi_cs_rom_n = cs_rom_reg;
   assign spi_cs_ram_n = cs_ram_reg;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: two instances (CLK_DIV 1 and 2) behind a select,
// a mode-0 SPI slave model that records MOSI and serves a read byte, a
// directed vector table, hand-written corner sequences and random traffic
// checked against a frame/latency/rdata model.
module tb_spi_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel_r = 1'b0;
   logic        cpu_req = 1'b0, dbg_req = 1'b0;
   logic [1:0]  cpu_op = 2'b00, dbg_op = 2'b00;
   logic [15:0] cpu_addr = '0, dbg_addr = '0;
   logic [7:0]  cpu_wdata = '0, dbg_wdata = '0;
   logic        miso;

   always #5 clk = ~clk;

   spi_mem_ctrl_if cpu0(), dbg0(), cpu1(), dbg1();
   assign cpu0.req = cpu_req && !sel_r;  assign cpu1.req = cpu_req && sel_r;
   assign dbg0.req = dbg_req && !sel_r;  assign dbg1.req = dbg_req && sel_r;
   assign cpu0.op = cpu_op;     assign cpu1.op = cpu_op;
   assign cpu0.addr = cpu_addr; assign cpu1.addr = cpu_addr;
   assign cpu0.wdata = cpu_wdata; assign cpu1.wdata = cpu_wdata;
   assign dbg0.op = dbg_op;     assign dbg1.op = dbg_op;
   assign dbg0.addr = dbg_addr; assign dbg1.addr = dbg_addr;
   assign dbg0.wdata = dbg_wdata; assign dbg1.wdata = dbg_wdata;

   logic [7:0] rdata0, rdata1;
   logic busy0, busy1, sclk0, sclk1, mosi0, mosi1, rom0, rom1, ram0, ram1;

   spi_mem_ctrl #(.CLK_DIV(1)) dut0 (
      .clk(clk), .rst(rst), .cpu(cpu0), .dbg(dbg0), .rdata(rdata0), .busy(busy0),
      .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_miso(miso),
      .spi_cs_rom_n(rom0), .spi_cs_ram_n(ram0));
   spi_mem_ctrl #(.CLK_DIV(2)) dut1 (
      .clk(clk), .rst(rst), .cpu(cpu1), .dbg(dbg1), .rdata(rdata1), .busy(busy1),
      .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(miso),
      .spi_cs_rom_n(rom1), .spi_cs_ram_n(ram1));

   logic       m_cpu_done, m_dbg_done, m_busy, m_sclk, m_mosi, m_cs_rom, m_cs_ram;
   logic [7:0] m_rdata;
   assign m_cpu_done = sel_r ? cpu1.done : cpu0.done;
   assign m_dbg_done = sel_r ? dbg1.done : dbg0.done;
   assign m_busy     = sel_r ? busy1 : busy0;
   assign m_sclk     = sel_r ? sclk1 : sclk0;
   assign m_mosi     = sel_r ? mosi1 : mosi0;
   assign m_cs_rom   = sel_r ? rom1 : rom0;
   assign m_cs_ram   = sel_r ? ram1 : ram0;
   assign m_rdata    = sel_r ? rdata1 : rdata0;

   // SPI slave model: capture MOSI on rising SCLK, present the response byte
   // MSB first during the last 8 frame bits, random bits elsewhere.
   logic [39:0] cap = '0;
   int          rises = 0;
   int          base = 0;
   int          rel;
   logic [7:0]  resp_byte = '0;
   always @(posedge m_sclk) begin
      cap   <= {cap[38:0], m_mosi};
      rises <= rises + 1;
   end
   always @(negedge m_sclk) begin
      rel = rises - base;
      if (rel >= 32 && rel < 40) miso = resp_byte[39 - rel];
      else                       miso = 1'($urandom);
   end

   int n_chk = 0, n_fail = 0;
   int cyc = 0, last_tog, hmin, hmax;
   bit rom_seen, ram_seen, both_seen, cpu_done_seen, dbg_done_seen;
   logic prev_sclk;
   logic [7:0] mdl_rdata [2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      rom_seen = 0; ram_seen = 0; both_seen = 0;
      cpu_done_seen = 0; dbg_done_seen = 0;
      hmin = 1000; hmax = 0; last_tog = -1; prev_sclk = m_sclk;
      base = rises;
   endtask

   task automatic step();
      @(posedge clk); #1;
      cyc++;
      if (!m_cs_rom) rom_seen = 1;
      if (!m_cs_ram) ram_seen = 1;
      if (!m_cs_rom && !m_cs_ram) both_seen = 1;
      if (m_cpu_done) cpu_done_seen = 1;
      if (m_dbg_done) dbg_done_seen = 1;
      if (m_sclk !== prev_sclk) begin
         if (last_tog >= 0) begin
            if (cyc - last_tog < hmin) hmin = cyc - last_tog;
            if (cyc - last_tog > hmax) hmax = cyc - last_tog;
         end
         last_tog = cyc;
         prev_sclk = m_sclk;
      end
   endtask

   // c = posedges until done seen, the first being the one that samples req
   task automatic wait_done(input bit port, input int budget, output int c, output bit ok);
      c = 0; ok = 0;
      while (c < budget && !ok) begin
         step();
         c++;
         if (port ? m_dbg_done : m_cpu_done) ok = 1;
      end
   endtask

   function automatic logic [39:0] mdl_frame(input logic [1:0] op, input logic [15:0] addr,
                                             input logic [7:0] wdata);
      if (op == 2'b10) return {8'h02, 8'h00, addr, wdata};
      return {8'h03, 8'h00, addr, 8'h00};
   endfunction

   task automatic run_txn(input bit sel, input bit port, input logic [1:0] op,
                          input logic [15:0] addr, input logic [7:0] wdata,
                          input logic [7:0] resp, input logic [39:0] exp_frame,
                          input int exp_lat, input logic [7:0] exp_rdata);
      int c, n;
      bit ok;
      int d;
      d = sel ? 2 : 1;
      sel_r = sel;
      #1;
      clear_mon();
      resp_byte = resp;
      if (port) begin dbg_op = op; dbg_addr = addr; dbg_wdata = wdata; dbg_req = 1; end
      else      begin cpu_op = op; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1; end
      wait_done(port, 400, c, ok);
      chk("done_timeout", 64'(ok), 64'd1);
      chk("latency", 64'(c - 1), 64'(exp_lat));
      chk("rdata_at_done", 64'(m_rdata), 64'(exp_rdata));
      chk("cs_rom_used", 64'(rom_seen), 64'(op == 2'b00));
      chk("cs_ram_used", 64'(ram_seen), 64'(op == 2'b01 || op == 2'b10));
      chk("both_cs_low", 64'(both_seen), 64'd0);
      chk("other_done", 64'(port ? cpu_done_seen : dbg_done_seen), 64'd0);
      if (op != 2'b11) begin
         chk("mosi_frame", 64'(cap), 64'(exp_frame));
         chk("sclk_rises", 64'(rises - base), 64'd40);
         chk("sclk_half_min", 64'(hmin), 64'(d));
         chk("sclk_half_max", 64'(hmax), 64'(d));
      end
      if (port) dbg_req = 0; else cpu_req = 0;
      n = 0;
      while (n < 10 && (port ? m_dbg_done : m_cpu_done)) begin step(); n++; end
      chk("done_fall", 64'(n), 64'd1);
      chk("busy_after", 64'(m_busy), 64'd0);
      chk("rdata_hold", 64'(m_rdata), 64'(exp_rdata));
      $display("txn div=%0d port=%s op=%0d addr=%04h wdata=%02h lat=%0d rdata=%02h",
               d, port ? "dbg" : "cpu", op, addr, wdata, c - 1, m_rdata);
      step();
   endtask

   typedef struct {
      bit sel; bit port; logic [1:0] op; logic [15:0] addr; logic [7:0] wdata;
      logic [7:0] resp; logic [39:0] frame; int lat; logic [7:0] rdata;
   } vec_t;
   vec_t vecs [4];

   initial begin
      int c, n;
      bit ok;
      vecs[0] = '{0, 0, 2'b00, 16'h1234, 8'h00, 8'hA5, 40'h0300123400, 83, 8'hA5};
      vecs[1] = '{0, 0, 2'b10, 16'h00FF, 8'h5C, 8'h3C, 40'h020000FF5C, 83, 8'hA5};
      vecs[2] = '{1, 1, 2'b01, 16'hABCD, 8'h00, 8'h6E, 40'h0300ABCD00, 163, 8'h6E};
      vecs[3] = '{1, 0, 2'b11, 16'h4444, 8'h77, 8'h00, 40'h0, 1, 8'h6E};
      mdl_rdata[0] = 8'h00; mdl_rdata[1] = 8'h00;

      // reset state
      step(); step();
      chk("rst_busy", 64'(m_busy), 64'd0);
      chk("rst_cs_rom", 64'(m_cs_rom), 64'd1);
      chk("rst_cs_ram", 64'(m_cs_ram), 64'd1);
      chk("rst_sclk", 64'(m_sclk), 64'd0);
      chk("rst_mosi", 64'(m_mosi), 64'd0);
      chk("rst_rdata", 64'(m_rdata), 64'd0);
      chk("rst_done", 64'({m_cpu_done, m_dbg_done}), 64'd0);
      rst = 0;
      step();

      // reset in the middle of a RAM write
      clear_mon();
      cpu_op = 2'b10; cpu_addr = 16'h0100; cpu_wdata = 8'hEE; cpu_req = 1;
      for (int i = 0; i < 30; i++) step();
      chk("pre_rst_cs_ram", 64'(m_cs_ram), 64'd0);
      rst = 1;
      #1;
      chk("mid_rst_cs_ram", 64'(m_cs_ram), 64'd1);
      chk("mid_rst_sclk", 64'(m_sclk), 64'd0);
      chk("mid_rst_busy", 64'(m_busy), 64'd0);
      chk("mid_rst_mosi", 64'(m_mosi), 64'd0);
      for (int i = 0; i < 3; i++) step();
      cpu_req = 0;
      rst = 0;
      step(); step();
      chk("mid_rst_no_done", 64'(cpu_done_seen), 64'd0);
      chk("post_rst_busy", 64'(m_busy), 64'd0);
      $display("txn reset mid-transfer checked");

      // directed vectors
      for (int i = 0; i < 4; i++) begin
         run_txn(vecs[i].sel, vecs[i].port, vecs[i].op, vecs[i].addr, vecs[i].wdata,
                 vecs[i].resp, vecs[i].frame, vecs[i].lat, vecs[i].rdata);
         mdl_rdata[vecs[i].sel] = vecs[i].rdata;
      end

      // simultaneous requests: dbg first, cpu only after dbg_req drops
      sel_r = 0; #1;
      clear_mon();
      resp_byte = 8'h11;
      cpu_op = 2'b00; cpu_addr = 16'h0010; cpu_wdata = 8'h00;
      dbg_op = 2'b01; dbg_addr = 16'h2000; dbg_wdata = 8'h00;
      cpu_req = 1; dbg_req = 1;
      wait_done(1, 400, c, ok);
      chk("arb_dbg_done", 64'(ok), 64'd1);
      chk("arb_dbg_lat", 64'(c - 1), 64'd83);
      chk("arb_cpu_not_done", 64'(cpu_done_seen), 64'd0);
      chk("arb_dbg_frame", 64'(cap), 64'(mdl_frame(2'b01, 16'h2000, 8'h00)));
      chk("arb_dbg_rdata", 64'(m_rdata), 64'h11);
      chk("arb_no_rom", 64'(rom_seen), 64'd0);
      clear_mon();
      for (int i = 0; i < 5; i++) step();
      chk("arb_hold_idle_bus", 64'({rom_seen, ram_seen, cpu_done_seen}), 64'd0);
      resp_byte = 8'h99;
      clear_mon();
      dbg_req = 0;
      wait_done(0, 400, c, ok);
      chk("arb_cpu_done", 64'(ok), 64'd1);
      // one DONE->IDLE cycle, then the cpu request is sampled in IDLE
      chk("arb_cpu_lat", 64'(c), 64'(1 + 80 + 3 + 1));
      chk("arb_cpu_frame", 64'(cap), 64'(mdl_frame(2'b00, 16'h0010, 8'h00)));
      chk("arb_cpu_rdata", 64'(m_rdata), 64'h99);
      chk("arb_dbg_done_gone", 64'(dbg_done_seen), 64'd0);
      cpu_req = 0;
      step(); step();
      mdl_rdata[0] = 8'h99;
      $display("txn arbitration dbg then cpu checked");

      // early request drop during SHIFT
      clear_mon();
      resp_byte = 8'h7E;
      cpu_op = 2'b01; cpu_addr = 16'h0042; cpu_req = 1;
      for (int i = 0; i < 20; i++) step();
      cpu_req = 0;
      wait_done(0, 400, c, ok);
      chk("drop_done", 64'(ok), 64'd1);
      chk("drop_lat", 64'(c + 20 - 1), 64'd83);
      n = 1;
      step();
      while (n < 10 && m_cpu_done) begin n++; step(); end
      chk("drop_done_width", 64'(n), 64'd1);
      chk("drop_rdata", 64'(m_rdata), 64'h7E);
      mdl_rdata[0] = 8'h7E;
      $display("txn early drop checked");

      // random traffic against the model
      for (int i = 0; i < 24; i++) begin
         bit s, p;
         logic [1:0] op;
         logic [15:0] a;
         logic [7:0] w, r, er;
         s = 1'($urandom_range(0, 1));
         p = 1'($urandom_range(0, 1));
         op = 2'($urandom_range(0, 3));
         a = 16'($urandom); w = 8'($urandom); r = 8'($urandom);
         er = (op == 2'b00 || op == 2'b01) ? r : mdl_rdata[s];
         run_txn(s, p, op, a, w, r, mdl_frame(op, a, w),
                 (op == 2'b11) ? 1 : 80 * (s ? 2 : 1) + 3, er);
         mdl_rdata[s] = er;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
